// File: rtl/bd_word_pkg.sv
// Shared definitions for unencoded BD words: default field widths, the leaf
// code stamped on spike-tag words, the packed {leaf, payload} word layout and
// the requester identifiers used by the tag-merge arbiter.
package bd_word_pkg;

  // Default field widths of an unencoded BD word and of a spike tag.
  localparam int NLEAF_DEF    = 5;
  localparam int NPAYLOAD_DEF = 24;
  localparam int NTAG_DEF     = 11;
  localparam int NCT_DEF      = 9;

  // Leaf code that marks a word as a tag word on the merged stream.
  localparam logic [NLEAF_DEF-1:0] TAG_LEAF_DEF = 5'd3;

  // Unencoded BD word: routing leaf code in the MSBs, payload below it.
  typedef struct packed {
    logic [NLEAF_DEF-1:0]    leaf;
    logic [NPAYLOAD_DEF-1:0] payload;
  } bd_word_t;

  // Identifies which requester was granted last.
  typedef enum logic {
    SRC_WORD = 1'b0,
    SRC_TAG  = 1'b1
  } bd_src_e;

endpackage

// File: rtl/bd_tag_merge_arb.sv
// Two-requester arbiter for the BD tag merge: PC words vs. spike tags.
// Default build: round-robin on contention, starting with the PC word.
// Build option BD_TAG_MERGE_TAG_PRIORITY_EN: tags win every contention.
// Grants are combinational and only issued when the output slot can load.
module bd_tag_merge_arb
  import bd_word_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_word_i,
  input  logic req_tag_i,
  input  logic load_ok_i,
  output logic gnt_word_o,
  output logic gnt_tag_o
);

  bd_src_e last_q;
  bd_src_e last_d;
  logic    pick_tag;

  // Choose a winner, gate it by load availability and reset, and work out
  // the new last-grant pointer (moves only when a grant is really issued,
  // which by construction coincides with a transfer).
  always_comb begin
    pick_tag = 1'b0;
    if (req_tag_i && !req_word_i) begin
      pick_tag = 1'b1;
    end else if (req_tag_i && req_word_i) begin
`ifdef BD_TAG_MERGE_TAG_PRIORITY_EN
      pick_tag = 1'b1;
`else
      pick_tag = (last_q == SRC_WORD);
`endif
    end

    gnt_word_o = !reset && load_ok_i && req_word_i && !pick_tag;
    gnt_tag_o  = !reset && load_ok_i && req_tag_i  &&  pick_tag;

    last_d = last_q;
    if (gnt_word_o) begin
      last_d = SRC_WORD;
    end else if (gnt_tag_o) begin
      last_d = SRC_TAG;
    end
  end

  // Last-grant pointer; reset to "tag" so the PC word wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= SRC_TAG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bd_tag_merge.sv
// BD tag merge: folds spike-generator tags into the PC-side BD word stream.
// PC words pass through untouched; a tag becomes {TAG_LEAF, 0.., ct, tag}.
// One output register with 1-cycle latency, reloadable while being drained
// so a 1 word/cycle stream is sustained.
// Build option BD_TAG_MERGE_TAG_PRIORITY_EN selects strict tag priority
// instead of round-robin (handled in bd_tag_merge_arb).
module bd_tag_merge
  import bd_word_pkg::*;
#(
  parameter int                NTAG     = NTAG_DEF,
  parameter int                NCT      = NCT_DEF,
  parameter int                NLEAF    = NLEAF_DEF,
  parameter int                NPAYLOAD = NPAYLOAD_DEF,
  parameter logic [NLEAF-1:0]  TAG_LEAF = TAG_LEAF_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      word_in_v,
  input  logic [NLEAF+NPAYLOAD-1:0] word_in_d,
  output logic                      word_in_a,
  input  logic                      tag_in_v,
  input  logic [NTAG-1:0]           tag_in_tag,
  input  logic [NCT-1:0]            tag_in_ct,
  output logic                      tag_in_a,
  output logic                      out_v,
  output logic [NLEAF+NPAYLOAD-1:0] out_d,
  input  logic                      out_a
);

  localparam int NW = NLEAF + NPAYLOAD;

  logic          out_v_q, out_v_d;
  logic [NW-1:0] out_d_q, out_d_d;
  logic          load_ok;
  logic          gnt_word, gnt_tag;
  logic [NPAYLOAD-1:0] tag_payload;
  logic [NW-1:0]       tag_word;

  // The output slot may take a new word when empty or drained this cycle.
  assign load_ok = !out_v_q || out_a;

  bd_tag_merge_arb u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_word_i (word_in_v),
    .req_tag_i  (tag_in_v),
    .load_ok_i  (load_ok),
    .gnt_word_o (gnt_word),
    .gnt_tag_o  (gnt_tag)
  );

  assign word_in_a = gnt_word;
  assign tag_in_a  = gnt_tag;

  // Tag payload: tag in the LSBs, count directly above, zeros up to the top.
  always_comb begin
    tag_payload                   = '0;
    tag_payload[NTAG-1:0]         = tag_in_tag;
    tag_payload[NTAG+NCT-1:NTAG]  = tag_in_ct;
  end

  assign tag_word = {TAG_LEAF, tag_payload};

  // Output slot next state: hold while stalled, otherwise load the granted word.
  always_comb begin
    out_v_d = out_v_q;
    out_d_d = out_d_q;
    if (load_ok) begin
      out_v_d = gnt_word || gnt_tag;
      if (gnt_word) begin
        out_d_d = word_in_d;
      end else if (gnt_tag) begin
        out_d_d = tag_word;
      end
    end
  end

  // Output register; reset only empties the slot, the data is don't-care then.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q <= 1'b0;
    end else begin
      out_v_q <= out_v_d;
    end
    out_d_q <= out_d_d;
  end

  assign out_v = out_v_q;
  assign out_d = out_d_q;

endmodule

// File: tb/tb_bd_tag_merge.sv
// Directed + random bench for bd_tag_merge (default widths).
// Expected words are pushed to a scoreboard when the reference model grants
// an input and popped when the output is drained.
module tb_bd_tag_merge;
  import bd_word_pkg::*;

`ifdef BD_TAG_MERGE_TAG_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        word_in_v;
  logic [28:0] word_in_d;
  logic        word_in_a;
  logic        tag_in_v;
  logic [10:0] tag_in_tag;
  logic [8:0]  tag_in_ct;
  logic        tag_in_a;
  logic        out_v;
  logic [28:0] out_d;
  logic        out_a;

  always #5 clk = ~clk;

  bd_tag_merge dut (
    .clk        (clk),
    .reset      (reset),
    .word_in_v  (word_in_v),
    .word_in_d  (word_in_d),
    .word_in_a  (word_in_a),
    .tag_in_v   (tag_in_v),
    .tag_in_tag (tag_in_tag),
    .tag_in_ct  (tag_in_ct),
    .tag_in_a   (tag_in_a),
    .out_v      (out_v),
    .out_d      (out_d),
    .out_a      (out_a)
  );

  int          total  = 0;
  int          passed = 0;
  logic [28:0] sb[$];
  logic        m_ov;
  logic        m_last_tag;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later.
  task automatic cycle(input logic wv, input logic [28:0] wd, input logic tv,
                       input logic [10:0] tg, input logic [8:0] ct,
                       input logic oa, input string nm);
    logic     lok, ew, et, pt;
    bd_word_t tw;
    word_in_v  = wv;
    word_in_d  = wd;
    tag_in_v   = tv;
    tag_in_tag = tg;
    tag_in_ct  = ct;
    out_a      = oa;
    #1;
    lok = !m_ov || oa;
    if (PRIO) pt = tv;
    else      pt = tv && (!wv || !m_last_tag);
    ew = lok && wv && !pt;
    et = lok && tv && pt;
    chk({nm, " word_in_a"}, 64'(word_in_a), 64'(ew));
    chk({nm, " tag_in_a"},  64'(tag_in_a),  64'(et));
    chk({nm, " out_v"},     64'(out_v),     64'(m_ov));
    if (m_ov) begin
      if (sb.size() == 0) begin
        chk({nm, " scoreboard empty"}, 64'(sb.size()), 64'd1);
      end else begin
        chk({nm, " out_d"}, 64'(out_d), 64'(sb[0]));
        if (oa) begin
          $display("[%0t] %s out_d=%h", $time, nm, out_d);
          void'(sb.pop_front());
        end
      end
    end
    if (lok) m_ov = ew || et;
    if (ew) begin
      sb.push_back(wd);
      m_last_tag = 1'b0;
    end
    if (et) begin
      tw.leaf    = 5'd3;
      tw.payload = {4'h0, ct, tg};
      sb.push_back(tw);
      m_last_tag = 1'b1;
    end
    @(negedge clk);
  endtask

  // Reset with both inputs requesting: acknowledges must stay low.
  task automatic do_reset(input string nm);
    reset     = 1'b1;
    word_in_v = 1'b1;
    tag_in_v  = 1'b1;
    out_a     = 1'b0;
    @(negedge clk);
    #1;
    chk({nm, " out_v"},     64'(out_v),     64'd0);
    chk({nm, " word_in_a"}, 64'(word_in_a), 64'd0);
    chk({nm, " tag_in_a"},  64'(tag_in_a),  64'd0);
    @(negedge clk);
    reset      = 1'b0;
    word_in_v  = 1'b0;
    tag_in_v   = 1'b0;
    m_ov       = 1'b0;
    m_last_tag = 1'b1;
    sb.delete();
  endtask

  initial begin
    reset      = 1'b1;
    word_in_v  = 1'b0;
    word_in_d  = '0;
    tag_in_v   = 1'b0;
    tag_in_tag = '0;
    tag_in_ct  = '0;
    out_a      = 1'b0;
    m_ov       = 1'b0;
    m_last_tag = 1'b1;
    @(negedge clk);
    do_reset("reset0");

    // Single PC word passes unchanged with one cycle of latency.
    cycle(1'b1, 29'h0ABCDEF, 1'b0, 11'h0, 9'h0, 1'b1, "pc_word");
    cycle(1'b0, 29'h0, 1'b0, 11'h0, 9'h0, 1'b1, "pc_drain");

    // Single tag: {3, 000FFF}.
    cycle(1'b0, 29'h0, 1'b1, 11'h7FF, 9'h001, 1'b1, "tag_7ff");
    cycle(1'b0, 29'h0, 1'b0, 11'h0, 9'h0, 1'b1, "tag_drain");
    chk("tag_word_value_seen", 64'(m_ov), 64'd0);

    // Zero-count tag is still forwarded, and a max-count tag fills the field.
    cycle(1'b0, 29'h0, 1'b1, 11'h123, 9'h000, 1'b1, "tag_ct0");
    cycle(1'b0, 29'h0, 1'b1, 11'h000, 9'h1FF, 1'b1, "tag_ctmax");
    cycle(1'b0, 29'h0, 1'b0, 11'h0, 9'h0, 1'b1, "tag_drain2");

    // Continuous contention after reset: word, tag, word, tag ...
    do_reset("reset1");
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 29'h1000000 + 29'(i), 1'b1, 11'(i + 16), 9'(i + 1), 1'b1, "contend");
    end

    // Downstream stall for 5 cycles: output held, inputs not acknowledged.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 29'h0C0FFEE, 1'b1, 11'h2AA, 9'h055, 1'b0, "stall");
    end
    cycle(1'b1, 29'h0C0FFEE, 1'b1, 11'h2AA, 9'h055, 1'b1, "unstall");
    cycle(1'b0, 29'h0, 1'b0, 11'h0, 9'h0, 1'b1, "unstall_drain");

    // Reset while a word is held; PC word must win the next contention.
    cycle(1'b0, 29'h0, 1'b1, 11'h055, 9'h00A, 1'b0, "pre_reset_load");
    cycle(1'b0, 29'h0, 1'b0, 11'h0, 9'h0, 1'b0, "pre_reset_hold");
    do_reset("reset_mid");
    cycle(1'b1, 29'h1F00001, 1'b1, 11'h3C3, 9'h033, 1'b1, "post_reset_contend");
    cycle(1'b1, 29'h1F00002, 1'b1, 11'h3C4, 9'h034, 1'b1, "post_reset_contend2");
    cycle(1'b0, 29'h0, 1'b0, 11'h0, 9'h0, 1'b1, "post_reset_drain");

    // Random traffic with random back-pressure.
    for (int i = 0; i < 80; i++) begin
      cycle(1'($urandom_range(0, 1)), 29'($urandom), 1'($urandom_range(0, 1)),
            11'($urandom), 9'($urandom), 1'($urandom_range(0, 3) != 0), "random");
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 29'h0, 1'b0, 11'h0, 9'h0, 1'b1, "final_drain");
    end
    chk("scoreboard_empty_at_end", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bd_tag_merge.md
BD_TAG_MERGE -- requirements
Module: bd_tag_merge

Interface
REQ-001 SHALL have parameter NTAG, default 11, tag field width.
REQ-002 SHALL have parameter NCT, default 9, count field width.
REQ-003 SHALL have parameter NLEAF, default 5, BD leaf-code width.
REQ-004 SHALL have parameter NPAYLOAD, default 24, BD payload width; NTAG+NCT <= NPAYLOAD.
REQ-005 SHALL have parameter TAG_LEAF, default 5'd3, leaf code stamped on tag words.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high.
REQ-007 SHALL have port word_in_v, input, 1, PC-side BD word valid.
REQ-008 SHALL have port word_in_d, input, NLEAF+NPAYLOAD, {leaf, payload} from the PC parser.
REQ-009 SHALL have port word_in_a, output, 1, PC-side word acknowledge.
REQ-010 SHALL have port tag_in_v, input, 1, spike-generator tag valid.
REQ-011 SHALL have port tag_in_tag, input, NTAG, tag.
REQ-012 SHALL have port tag_in_ct, input, NCT, count.
REQ-013 SHALL have port tag_in_a, output, 1, tag acknowledge.
REQ-014 SHALL have port out_v, output, 1, merged word valid.
REQ-015 SHALL have port out_d, output, NLEAF+NPAYLOAD, merged unencoded BD word.
REQ-016 SHALL have port out_a, input, 1, downstream (encoder) acknowledge.

Function
REQ-017 SHALL treat a transfer on any channel as occurring on a rising clk edge with v=1 and a=1.
REQ-018 SHALL hold out_d stable while out_v=1 and out_a=0.
REQ-019 SHALL register the output: word accepted at edge N appears on out_v/out_d after edge N (1-cycle latency).
REQ-020 SHALL be able to load the output register when it is empty or being drained in the same cycle (load_ok = !out_v | out_a), giving 1 word/cycle sustained.
REQ-021 SHALL assert at most one of word_in_a/tag_in_a per cycle, only when load_ok and the chosen input's v=1.
REQ-022 SHALL drive a signals combinationally from v, load_ok and arbiter state; SHALL NOT assert a with v=0.
REQ-023 SHALL forward a PC word unchanged: out_d = word_in_d.
REQ-024 SHALL form a tag word as out_d = {TAG_LEAF, zero-extend({ct, tag})}, tag in LSBs, ct above it.
REQ-025 SHALL forward ct=0 tags unchanged.
REQ-026 SHALL arbitrate round-robin when both inputs are valid: grant the source not granted last; single valid source granted immediately.
REQ-027 SHALL update the last-grant pointer only on an actual input transfer.
REQ-028 SHALL stall both inputs (a=0) while out_v=1 and out_a=0.

Reset
REQ-029 SHALL, while reset=1, drive out_v=0, word_in_a=0, tag_in_a=0.
REQ-030 SHALL set last-grant to tag on reset, so the PC word wins the first contention.
REQ-031 SHALL discard any held output word when reset is asserted mid-transfer; out_d value is don't-care while out_v=0.

Configuration
REQ-032 SHALL, with BD_TAG_MERGE_TAG_PRIORITY_EN defined, give tags strict priority when both inputs are valid; PC words are granted only when tag_in_v=0.
REQ-033 SHALL use round-robin per REQ-026 without BD_TAG_MERGE_TAG_PRIORITY_EN.

Structure
REQ-034 SHALL take NLEAF, NPAYLOAD, NTAG, NCT defaults, the TAG_LEAF constant and a packed unencoded-word struct {leaf, payload} from shared package bd_word_pkg.
REQ-035 SHALL place the two-requester arbiter (round-robin / priority, grant pointer) in sub-module bd_tag_merge_arb; muxing and output register stay in bd_tag_merge.

Verification
REQ-036 SHALL verify: only word_in_v=1 with d=29'h0ABCDEF, out_a=1 -> word_in_a=1 that cycle, next cycle out_v=1, out_d=29'h0ABCDEF.
REQ-037 SHALL verify: only tag_in_v=1, tag=11'h7FF, ct=9'h001 -> out_d={5'd3, 24'h000FFF} one cycle later.
REQ-038 SHALL verify: both inputs continuously valid, out_a=1 after reset -> grants alternate word, tag, word, tag; one output per cycle.
REQ-039 SHALL verify: out_v=1 with out_a=0 for 5 cycles -> out_d unchanged, both input a=0; on out_a=1 the next queued word loads the same edge.
REQ-040 SHALL verify: reset pulsed while out_v=1 -> out_v=0 next cycle, arbiter restarts with the PC word winning contention.
REQ-041 SHALL verify: with BD_TAG_MERGE_TAG_PRIORITY_EN defined and both inputs valid for 4 cycles -> 4 tag words out, word_in_a stays 0.
